// File: rtl/sprite_evaluator_if.sv
// Scanline evaluator bus: start request, primary OAM read port, secondary OAM
// write port and scan results.
interface sprite_evaluator_if;
   logic        start;
   logic [7:0]  target_line;
   logic        tall_sprites;
   logic [5:0]  oam_read_addr;
   logic [31:0] oam_read_data;
   logic        sec_wr_en;
   logic [2:0]  sec_wr_addr;
   logic [31:0] sec_wr_data;
   logic [3:0]  sprite_count;
   logic        overflow;
   logic        sprite0_hit;
   logic        busy;
   logic        done;

   modport master (
      output start, target_line, tall_sprites, oam_read_data,
      input  oam_read_addr, sec_wr_en, sec_wr_addr, sec_wr_data,
             sprite_count, overflow, sprite0_hit, busy, done
   );

   modport slave (
      input  start, target_line, tall_sprites, oam_read_data,
      output oam_read_addr, sec_wr_en, sec_wr_addr, sec_wr_data,
             sprite_count, overflow, sprite0_hit, busy, done
   );
endinterface

// File: rtl/sprite_evaluator.sv
// Scans primary OAM for sprites on one scanline and copies up to MAX_SPRITES
// hits into secondary OAM, flagging overflow and a sprite-0 hit.
module sprite_evaluator #(
   parameter int NUM_ENTRIES = 64,
   parameter int MAX_SPRITES = 8
) (
   input  logic              clk,
   input  logic              reset,
   sprite_evaluator_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [5:0] LAST_ADDR = 6'(NUM_ENTRIES - 1);
   localparam logic [3:0] MAX_CNT   = 4'(MAX_SPRITES);

   state_t      state_r;
   logic [7:0]  line_r;
   logic        tall_r;
   logic [5:0]  addr_r;
   logic        eval_valid_r;
   logic [5:0]  eval_idx_r;
   logic [3:0]  count_r;
   logic        overflow_r;
   logic        sprite0_r;
   logic        busy_r;
   logic        done_r;
   logic        wr_en_r;
   logic [2:0]  wr_addr_r;
   logic [31:0] wr_data_r;

   logic [8:0]  diff_s;
   logic [7:0]  height_s;
   logic        hit_s;
   logic        full_s;

   // Hit test on the entry returned this cycle; the 9-bit borrow rejects wrap.
   always_comb begin
      diff_s   = {1'b0, line_r} - {1'b0, bus.oam_read_data[31:24]};
      height_s = tall_r ? 8'd16 : 8'd8;
      if (eval_valid_r && !diff_s[8] && (diff_s[7:0] < height_s)) begin
         hit_s = 1'b1;
      end else begin
         hit_s = 1'b0;
      end
      full_s = (count_r == MAX_CNT);
   end

   // Scan sequencer, result collection and secondary OAM write port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         line_r       <= 8'd0;
         tall_r       <= 1'b0;
         addr_r       <= 6'd0;
         eval_valid_r <= 1'b0;
         eval_idx_r   <= 6'd0;
         count_r      <= 4'd0;
         overflow_r   <= 1'b0;
         sprite0_r    <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         wr_en_r      <= 1'b0;
         wr_addr_r    <= 3'd0;
         wr_data_r    <= 32'd0;
      end else begin
         wr_en_r <= 1'b0;
         done_r  <= 1'b0;

         if (hit_s && !full_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= count_r[2:0];
            wr_data_r <= bus.oam_read_data;
            count_r   <= count_r + 4'd1;
            if (eval_idx_r == 6'd0) begin
               sprite0_r <= 1'b1;
            end
         end

         case (state_r)
            IDLE: begin
               eval_valid_r <= 1'b0;
               addr_r       <= 6'd0;
               // A start coinciding with done is deliberately dropped.
               if (bus.start && !done_r) begin
                  line_r     <= bus.target_line;
                  tall_r     <= bus.tall_sprites;
                  count_r    <= 4'd0;
                  overflow_r <= 1'b0;
                  sprite0_r  <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= SCAN;
               end
            end
            SCAN: begin
               eval_valid_r <= 1'b1;
               eval_idx_r   <= addr_r;
               if (addr_r == LAST_ADDR) begin
                  addr_r  <= 6'd0;
                  state_r <= FINISH;
               end else begin
                  addr_r <= addr_r + 6'd1;
               end
            end
            FINISH: begin
               eval_valid_r <= 1'b0;
               busy_r       <= 1'b0;
               done_r       <= 1'b1;
               state_r      <= IDLE;
            end
            default: begin
               eval_valid_r <= 1'b0;
               busy_r       <= 1'b0;
               addr_r       <= 6'd0;
               state_r      <= IDLE;
            end
         endcase

         // One hit too many ends the scan at once; later data is discarded.
         if (hit_s && full_s) begin
            overflow_r   <= 1'b1;
            eval_valid_r <= 1'b0;
            addr_r       <= 6'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b1;
            state_r      <= IDLE;
         end
      end
   end

   assign bus.oam_read_addr = addr_r;
   assign bus.sec_wr_en     = wr_en_r;
   assign bus.sec_wr_addr   = wr_addr_r;
   assign bus.sec_wr_data   = wr_data_r;
   assign bus.sprite_count  = count_r;
   assign bus.overflow      = overflow_r;
   assign bus.sprite0_hit   = sprite0_r;
   assign bus.busy          = busy_r;
   assign bus.done          = done_r;
endmodule

// File: tb/tb_sprite_evaluator.sv
// Directed bench for sprite_evaluator: a scanline model predicts every cycle
// of each scan from the OAM contents, plus literal end-of-scan expectations.
module tb_sprite_evaluator;
   logic clk;
   logic reset;
   sprite_evaluator_if bus ();

   sprite_evaluator #(.NUM_ENTRIES(64), .MAX_SPRITES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [0:63];

   // Primary OAM: synchronous read, data one cycle after the address.
   always @(posedge clk) bus.oam_read_data <= mem[bus.oam_read_addr];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void fill(input logic [7:0] dflt);
      for (int i = 0; i < 64; i++) begin
         mem[i] = {dflt, 8'(i), 8'(i) ^ 8'h5A, 8'(i * 3)};
      end
   endfunction

   function automatic void set_y(input int idx, input logic [7:0] y);
      mem[idx][31:24] = y;
   endfunction

   // Expected per-cycle behaviour, indexed by cycles after the first busy cycle.
   logic        e_wr   [0:79];
   logic [2:0]  e_slot [0:79];
   logic [31:0] e_data [0:79];
   int          e_done;
   int          e_count;
   logic        e_ovf;
   logic        e_s0;

   function automatic void model(input int line, input bit tall);
      int k;
      int h;
      int y;
      k = 0;
      h = tall ? 16 : 8;
      e_ovf  = 1'b0;
      e_s0   = 1'b0;
      e_done = 65;
      for (int c = 0; c < 80; c++) begin
         e_wr[c] = 1'b0; e_slot[c] = 3'd0; e_data[c] = 32'd0;
      end
      for (int i = 0; i < 64; i++) begin
         y = int'(mem[i][31:24]);
         if (line >= y && line - y < h) begin
            if (i == 0) e_s0 = 1'b1;
            if (k == 8) begin
               e_ovf  = 1'b1;
               e_done = i + 2;
               break;
            end
            e_wr[i + 2]   = 1'b1;
            e_slot[i + 2] = 3'(k);
            e_data[i + 2] = mem[i];
            k++;
         end
      end
      e_count = k;
   endfunction

   task automatic run_scan(input logic [7:0] line, input bit tall,
                           input int lit_count, input bit lit_ovf, input bit lit_s0);
      int cnt;
      model(int'(line), tall);
      chk("model_count", 32'(e_count), 32'(lit_count));
      chk("model_ovf", 32'(e_ovf), 32'(lit_ovf));
      @(negedge clk);
      bus.start        = 1'b1;
      bus.target_line  = line;
      bus.tall_sprites = tall;
      @(negedge clk);
      bus.start        = 1'b0;
      bus.target_line  = ~line;
      bus.tall_sprites = ~tall;
      cnt = 0;
      for (int rel = 0; rel <= e_done + 2; rel++) begin
         if (e_wr[rel]) cnt++;
         chk($sformatf("addr@%0d", rel), 32'(bus.oam_read_addr),
             (rel < e_done && rel <= 63) ? 32'(rel) : 32'd0);
         chk($sformatf("busy@%0d", rel), 32'(bus.busy), 32'(rel < e_done));
         chk($sformatf("done@%0d", rel), 32'(bus.done), 32'(rel == e_done));
         chk($sformatf("wr_en@%0d", rel), 32'(bus.sec_wr_en), 32'(e_wr[rel]));
         if (e_wr[rel]) begin
            chk($sformatf("wr_addr@%0d", rel), 32'(bus.sec_wr_addr), 32'(e_slot[rel]));
            chk($sformatf("wr_data@%0d", rel), bus.sec_wr_data, e_data[rel]);
         end
         chk($sformatf("count@%0d", rel), 32'(bus.sprite_count), 32'(cnt));
         chk($sformatf("ovf@%0d", rel), 32'(bus.overflow), 32'(e_ovf && rel >= e_done));
         chk($sformatf("s0@%0d", rel), 32'(bus.sprite0_hit), 32'(e_s0 && rel >= 2));
         // Starts while busy and in the done cycle must both be ignored.
         bus.start = (rel == 5 || rel == e_done);
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk("final_count", 32'(bus.sprite_count), 32'(lit_count));
      chk("final_ovf", 32'(bus.overflow), 32'(lit_ovf));
      chk("final_s0", 32'(bus.sprite0_hit), 32'(lit_s0));
      chk("idle_after", 32'(bus.busy), 32'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"}, 32'(bus.oam_read_addr), 32'd0);
      chk({tag, "_wr"}, 32'(bus.sec_wr_en), 32'd0);
      chk({tag, "_count"}, 32'(bus.sprite_count), 32'd0);
      chk({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
      chk({tag, "_s0"}, 32'(bus.sprite0_hit), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      bus.start        = 1'b0;
      bus.target_line  = 8'd0;
      bus.tall_sprites = 1'b0;
      fill(8'hF0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      reset = 1'b0;

      // No sprite anywhere near the line.
      run_scan(8'h10, 1'b0, 0, 1'b0, 1'b0);

      // Entries 0, 5, 63 sit on the line.
      set_y(0, 8'h20); set_y(5, 8'h20); set_y(63, 8'h20);
      run_scan(8'h27, 1'b0, 3, 1'b0, 1'b1);
      chk("slots_at_2_7_65", {29'd0, e_wr[2], e_wr[7], e_wr[65]}, 32'd7);

      // Line 8 rows below Y: outside a short sprite, inside a tall one.
      run_scan(8'h28, 1'b0, 0, 1'b0, 1'b0);
      run_scan(8'h28, 1'b1, 3, 1'b0, 1'b1);
      run_scan(8'h2F, 1'b1, 3, 1'b0, 1'b1);
      run_scan(8'h30, 1'b1, 0, 1'b0, 1'b0);

      // Ten sprites on one line: eight stored, ninth overflows at cycle 10.
      fill(8'hF0);
      for (int i = 0; i < 10; i++) set_y(i, 8'h30);
      run_scan(8'h30, 1'b0, 8, 1'b1, 1'b1);
      chk("ovf_done_at", 32'(e_done), 32'd10);

      // No wrap past line 255; bottom edge still hits.
      fill(8'hF0);
      set_y(3, 8'hFA);
      run_scan(8'h02, 1'b1, 0, 1'b0, 1'b0);
      run_scan(8'hFF, 1'b0, 1, 1'b0, 1'b0);

      // Reset in the middle of a scan, then a clean rerun.
      fill(8'hF0);
      set_y(0, 8'h20); set_y(5, 8'h20); set_y(63, 8'h20);
      @(negedge clk);
      bus.start = 1'b1; bus.target_line = 8'h27; bus.tall_sprites = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (20) @(negedge clk);
      chk("mid_busy", 32'(bus.busy), 32'd1);
      chk("mid_addr", 32'(bus.oam_read_addr), 32'd20);
      reset = 1'b1;
      #1;
      chk_zero("midrst");
      @(negedge clk);
      reset = 1'b0;
      run_scan(8'h27, 1'b0, 3, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
